// File: rtl/dt_pkg.sv
// dt_pkg: shared state type and sizing constants for the DT frame controller
package dt_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, RUN, HOLD} state_t;
  localparam int RES_DEPTH = 16384;
  localparam int ADDR_W = 14;
  localparam int DEF_TIMEOUT = 131072;
endpackage

// File: rtl/dt_res_mux.sv
// dt_res_mux: result-memory port mux between clear walker, engine and host reads
module dt_res_mux
  import dt_pkg::*;
#(
  parameter int ADDR_W = dt_pkg::ADDR_W
) (
  input  state_t            state,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              host_req,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              dt_wr,
  input  logic              dt_rd,
  input  logic              dt_done,
  input  logic [ADDR_W-1:0] dt_addr,
  input  logic [7:0]        dt_do,
  output logic              res_wr,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_do
);
  // engine owns the port in RUN, but a write coinciding with done is dropped
  always_comb begin
    res_wr   = state == CLEAR || (state == RUN && dt_wr && !dt_done);
    res_rd   = state == RUN ? dt_rd : host_req;
    res_addr = state == CLEAR ? clr_addr : state == RUN ? dt_addr : host_req ? host_addr : '0;
    res_do   = state == RUN ? dt_do : '0;
  end
endmodule

// File: rtl/dt_frame_ctrl.sv
// dt_frame_ctrl: clears the result memory, runs the DT engine, then serves host reads
module dt_frame_ctrl
  import dt_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ADDR_W  = dt_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic              rd_ready,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_valid,
  output logic [7:0]        rd_data,
  output logic              dt_rst_n,
  input  logic              dt_done,
  input  logic              dt_res_wr,
  input  logic              dt_res_rd,
  input  logic [ADDR_W-1:0] dt_res_addr,
  input  logic [7:0]        dt_res_do,
  output logic [7:0]        dt_res_di,
  output logic              res_wr,
  output logic              res_rd,
  output logic [ADDR_W-1:0] res_addr,
  output logic [7:0]        res_do,
  input  logic [7:0]        res_di
);
  localparam int TO_W = $clog2(TIMEOUT);
  state_t state, state_n;
  logic [ADDR_W-1:0] clr_cnt;
  logic [TO_W-1:0] to_cnt;
  logic idle_like, host_req, clr_last, to_hit;
  assign clr_last  = clr_cnt == '1;
  assign to_hit    = to_cnt == TO_W'(TIMEOUT - 1);
  assign dt_res_di = res_di;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_n;
  // next-state: done beats timeout since both simply lead to HOLD
  always_comb begin
    state_n = state;
    case (state)
      IDLE, HOLD: if (start) state_n = CLEAR;
      CLEAR:      if (clr_last) state_n = RUN;
      RUN:        if (dt_done || to_hit) state_n = HOLD;
      default:    state_n = IDLE;
    endcase
  end
  // outputs: rd_ready is gated by rst so it reads 0 while reset is held
  always_comb begin
    idle_like = state == IDLE || state == HOLD;
    busy      = !idle_like;
    rd_ready  = rst && idle_like;
    host_req  = rd_req && rd_ready;
  end
  // counters, engine reset, frame flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      clr_cnt    <= '0;
      to_cnt     <= '0;
      err        <= 1'b0;
      dt_rst_n   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      clr_cnt    <= state == CLEAR ? clr_cnt + 1'b1 : '0;
      to_cnt     <= state == RUN ? to_cnt + 1'b1 : '0;
      err        <= (idle_like && start) ? 1'b0 : (state == RUN && !dt_done && to_hit) ? 1'b1 : err;
      dt_rst_n   <= state_n == RUN;
      frame_done <= state == RUN && state_n == HOLD;
    end
  // host read data register, one-cycle latency
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= host_req;
      rd_data  <= host_req ? res_di : rd_data;
    end
  dt_res_mux #(.ADDR_W(ADDR_W)) u_mux (
    .state     (state),
    .clr_addr  (clr_cnt),
    .host_req  (host_req),
    .host_addr (rd_addr),
    .dt_wr     (dt_res_wr),
    .dt_rd     (dt_res_rd),
    .dt_done   (dt_done),
    .dt_addr   (dt_res_addr),
    .dt_do     (dt_res_do),
    .res_wr    (res_wr),
    .res_rd    (res_rd),
    .res_addr  (res_addr),
    .res_do    (res_do)
  );
endmodule
